event_dispatcher: RTL and testbench
===================================

Name: event_dispatcher

Overview:
Issue side of the core event interface. Takes the head event of the pending-event queue and assigns it to an idle, non-stalled core. It emits the {LP id, timestamp} message, the target core id and a one-cycle sent_msg_vld strobe, which is the stream that core_monitor consumes. It tracks per-core busy state from core completions, blocks events whose LP is already in flight, and reports the minimum in-flight timestamp.

Parameters:
NUM_CORE, 4, number of simulation cores
NUM_LP, 8, number of logical processes
TIME_WID, 16, timestamp width
MSG_WID, 32, message width; msg = {LP field [MSG_WID-1:TIME_WID], time [TIME_WID-1:0]}
NB_CORE, $clog2(NUM_CORE), core id width (derived)
NB_LP, $clog2(NUM_LP), LP id width (derived)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
ev_msg  in  MSG_WID  head event from event queue
ev_vld  in  1  ev_msg valid
ev_rdy  out  1  event accepted this cycle (combinational)
stall  in  NUM_CORE  per-core stall from core_monitor; a stalled core is not selected
done_vld  in  1  a core finished its event
done_core_id  in  NB_CORE  core reporting completion
msg  out  MSG_WID  dispatched event (registered)
core_id  out  NB_CORE  target core (registered)
sent_msg_vld  out  1  one-cycle dispatch strobe (registered)
busy  out  NUM_CORE  per-core busy vector (registered)
gvt  out  TIME_WID  minimum timestamp over busy cores (registered)
err  out  1  sticky protocol error

Behaviour:
- Reset (reset_n=0, async): busy=0, msg=0, core_id=0, sent_msg_vld=0, err=0, gvt={TIME_WID{1'b1}}, per-core lp/time regs cleared.
- LP of incoming event = ev_msg[TIME_WID+NB_LP-1:TIME_WID]. Upper LP-field bits are ignored. time = ev_msg[TIME_WID-1:0].
- candidate[c] = !busy[c] && !stall[c]. sel = lowest-index c with candidate[c]=1.
- conflict = any c with busy[c] && lp_reg[c]==LP of ev_msg.
- ev_rdy = ev_vld && |candidate && !conflict. ev_rdy may depend on ev_vld, and the queue must not depend on ev_rdy to drive ev_vld.
- On a clock edge with ev_rdy=1, the next cycle shows:
  - sent_msg_vld=1, msg=ev_msg, core_id=sel.
  - busy[sel]=1; lp_reg[sel] and time_reg[sel] loaded.
  - Latency from accept to strobe is 1 cycle.
- Otherwise sent_msg_vld=0 next cycle. msg and core_id hold their last values.
- At most one dispatch per cycle.
- Completion: done_vld=1 clears busy[done_core_id] at the edge.
  - If busy[done_core_id] was already 0: err is set (sticky until reset) and nothing else changes.
  - done_core_id >= NUM_CORE also sets err.
- Same cycle done(c) and dispatch:
  - Selection and conflict use registered busy, so c is not re-selected and its LP is not released until the following cycle.
  - Both updates apply; they target different cores.
- stall is sampled only for selection. It never cancels or modifies a dispatch already accepted.
- gvt is registered each cycle as the min of time_reg[c] over busy[c]=1, using busy before this edge's updates. With no core busy, gvt={TIME_WID{1'b1}}. Equal times: value only, no tie-break needed.
- Reset mid-operation clears all in-flight state immediately. An accept in the same cycle as reset assertion is lost.
- ev_vld=1 with all cores busy or stalled: ev_rdy=0, the event stays held, no error.

Test Plan:
- Reset, then ev_msg={16'd1,16'd25}, ev_vld=1 for 1 cycle, stall=0 -> ev_rdy=1; next cycle sent_msg_vld=1, core_id=0, msg=0x00010019, busy=0001; one cycle later gvt=25.
- Back-to-back LPs 1,2,3,4 with times 25,35,40,45 -> core_id 0,1,2,3 on consecutive cycles, busy=1111. A fifth event LP5 is held, ev_rdy=0. gvt=25.
- Busy LP2 on core1, offer {16'd2,16'd50} -> ev_rdy=0. Then done_vld with done_core_id=1 -> ev_rdy=1 one cycle after busy[1] clears; event goes to core1.
- stall=0001, core0 idle, ev {16'd6,16'd60} -> dispatched to core1. Raising stall[1] after the accept leaves busy[1]=1.
- done_vld with done_core_id=2 while busy[2]=0 -> err=1 and stays 1. busy is unchanged.
- Same cycle: done for core0 (LP1, t=25) and accept of LP7 t=70 with cores 1-3 idle -> LP7 goes to core1, busy[0] cleared. gvt moves 25 -> 70 once the registered busy reflects both updates.

Source files
------------

// File: rtl/event_dispatcher.sv
// event_dispatcher
//   Issue side of the core event interface. Accepts the head event of the
//   pending-event queue, assigns it to the lowest-index idle, non-stalled
//   core, and emits a registered {LP, time} message with a one-cycle strobe.
//   Tracks per-core busy state, blocks events whose LP is already in flight,
//   and reports the minimum in-flight timestamp (gvt).
//
// Ports
//   clk           in   clock, all state on rising edge
//   reset_n       in   asynchronous active-low reset
//   ev_msg        in   head event {LP field, time}
//   ev_vld        in   ev_msg valid
//   ev_rdy        out  event accepted this cycle (combinational)
//   stall         in   per-core stall, excludes a core from selection
//   done_vld      in   a core finished its event
//   done_core_id  in   core reporting completion
//   msg           out  dispatched event (registered)
//   core_id       out  target core (registered)
//   sent_msg_vld  out  one-cycle dispatch strobe
//   busy          out  per-core busy vector
//   gvt           out  minimum timestamp over busy cores
//   err           out  sticky protocol error (completion from an idle/invalid core)
module event_dispatcher #(
    parameter int NUM_CORE = 4,
    parameter int NUM_LP   = 8,
    parameter int TIME_WID = 16,
    parameter int MSG_WID  = 32,
    parameter int NB_CORE  = $clog2(NUM_CORE),
    parameter int NB_LP    = $clog2(NUM_LP)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [MSG_WID-1:0]  ev_msg,
    input  logic                ev_vld,
    output logic                ev_rdy,
    input  logic [NUM_CORE-1:0] stall,
    input  logic                done_vld,
    input  logic [NB_CORE-1:0]  done_core_id,
    output logic [MSG_WID-1:0]  msg,
    output logic [NB_CORE-1:0]  core_id,
    output logic                sent_msg_vld,
    output logic [NUM_CORE-1:0] busy,
    output logic [TIME_WID-1:0] gvt,
    output logic                err
);

    logic [MSG_WID-1:0]  msg_q;
    logic [NB_CORE-1:0]  core_id_q;
    logic                sent_q;
    logic [NUM_CORE-1:0] busy_q, busy_d;
    logic [TIME_WID-1:0] gvt_q, gvt_d;
    logic                err_q, err_d;
    logic [NB_LP-1:0]    lp_q   [NUM_CORE];
    logic [TIME_WID-1:0] time_q [NUM_CORE];

    logic [NB_LP-1:0]    ev_lp;
    logic [TIME_WID-1:0] ev_time;
    logic [NUM_CORE-1:0] cand;
    logic [NB_CORE-1:0]  sel;
    logic                any_cand;
    logic                conflict;
    logic                done_in_range;
    logic                done_ok;

    // Only the low NB_LP bits of the LP field identify the LP.
    assign ev_lp   = ev_msg[TIME_WID+NB_LP-1:TIME_WID];
    assign ev_time = ev_msg[TIME_WID-1:0];
    assign cand    = ~busy_q & ~stall;

    always_comb begin
        sel      = '0;
        any_cand = 1'b0;
        for (int c = NUM_CORE - 1; c >= 0; c--) begin
            if (cand[c]) begin
                sel      = NB_CORE'(c);
                any_cand = 1'b1;
            end
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int c = 0; c < NUM_CORE; c++) begin
            if (busy_q[c] && (lp_q[c] == ev_lp)) conflict = 1'b1;
        end
    end

    assign ev_rdy = ev_vld && any_cand && !conflict;

    assign done_in_range = (32'(done_core_id) < NUM_CORE);
    assign done_ok       = done_vld && done_in_range && busy_q[done_core_id];

    // A completing core is busy and a selected core is idle in the registered
    // view, so the clear and the set can never hit the same bit.
    always_comb begin
        busy_d = busy_q;
        if (done_ok) busy_d[done_core_id] = 1'b0;
        if (ev_rdy)  busy_d[sel]          = 1'b1;
    end

    always_comb begin
        err_d = err_q;
        if (done_vld && !done_ok) err_d = 1'b1;
    end

    // gvt looks at the busy set before this edge's updates.
    always_comb begin
        gvt_d = {TIME_WID{1'b1}};
        for (int c = 0; c < NUM_CORE; c++) begin
            if (busy_q[c] && (time_q[c] < gvt_d)) gvt_d = time_q[c];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_q     <= '0;
            core_id_q <= '0;
            sent_q    <= 1'b0;
            busy_q    <= '0;
            gvt_q     <= {TIME_WID{1'b1}};
            err_q     <= 1'b0;
            for (int c = 0; c < NUM_CORE; c++) begin
                lp_q[c]   <= '0;
                time_q[c] <= '0;
            end
        end else begin
            sent_q <= ev_rdy;
            busy_q <= busy_d;
            gvt_q  <= gvt_d;
            err_q  <= err_d;
            if (ev_rdy) begin
                msg_q          <= ev_msg;
                core_id_q      <= sel;
                lp_q[sel]      <= ev_lp;
                time_q[sel]    <= ev_time;
            end
        end
    end

    assign msg          = msg_q;
    assign core_id      = core_id_q;
    assign sent_msg_vld = sent_q;
    assign busy         = busy_q;
    assign gvt          = gvt_q;
    assign err          = err_q;

endmodule

// File: tb/tb_event_dispatcher.sv
module tb_event_dispatcher;

    logic        clk;
    logic        reset_n;
    logic [31:0] ev_msg;
    logic        ev_vld;
    logic        ev_rdy;
    logic [3:0]  stall;
    logic        done_vld;
    logic [1:0]  done_core_id;
    logic [31:0] msg;
    logic [1:0]  core_id;
    logic        sent_msg_vld;
    logic [3:0]  busy;
    logic [15:0] gvt;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] m;
        logic [1:0]  c;
    } disp_t;
    disp_t sb_q[$];

    event_dispatcher dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ev_msg       (ev_msg),
        .ev_vld       (ev_vld),
        .ev_rdy       (ev_rdy),
        .stall        (stall),
        .done_vld     (done_vld),
        .done_core_id (done_core_id),
        .msg          (msg),
        .core_id      (core_id),
        .sent_msg_vld (sent_msg_vld),
        .busy         (busy),
        .gvt          (gvt),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: every strobe must match the oldest expected dispatch.
    always @(negedge clk) begin
        if (reset_n && sent_msg_vld) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                disp_t e;
                e = sb_q.pop_front();
                chk("disp_msg", msg, e.m);
                chk("disp_core", 32'(core_id), 32'(e.c));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        ev_vld   = 1'b0;
        done_vld = 1'b0;
        #1;
    endtask

    task automatic offer(input logic [15:0] lp, input logic [15:0] t);
        @(negedge clk);
        ev_msg   = {lp, t};
        ev_vld   = 1'b1;
        done_vld = 1'b0;
        #1;
    endtask

    task automatic expect_accept(input logic [1:0] core);
        disp_t e;
        chk("ev_rdy_accept", 32'(ev_rdy), 32'd1);
        e.m = ev_msg;
        e.c = core;
        sb_q.push_back(e);
    endtask

    task automatic send(input logic [15:0] lp, input logic [15:0] t, input logic [1:0] core);
        offer(lp, t);
        expect_accept(core);
    endtask

    task automatic done_pulse(input logic [1:0] id);
        @(negedge clk);
        ev_vld       = 1'b0;
        done_vld     = 1'b1;
        done_core_id = id;
        @(negedge clk);
        done_vld = 1'b0;
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        ev_msg       = '0;
        ev_vld       = 1'b0;
        stall        = '0;
        done_vld     = 1'b0;
        done_core_id = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_gvt", 32'(gvt), 32'hFFFF);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_sent", 32'(sent_msg_vld), 32'd0);
        chk("rst_msg", msg, 32'h0);
        chk("rst_core", 32'(core_id), 32'd0);
        reset_n = 1'b1;

        // single dispatch
        send(16'd1, 16'd25, 2'd0);
        chk("t1_msg_lit", ev_msg, 32'h0001_0019);
        step();
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_gvt_lag", 32'(gvt), 32'hFFFF);
        step();
        chk("t1_gvt", 32'(gvt), 32'd25);
        chk("t1_sent_low", 32'(sent_msg_vld), 32'd0);
        chk("t1_core_hold", 32'(core_id), 32'd0);

        // back-to-back fill, then a fifth event is held
        send(16'd2, 16'd35, 2'd1);
        send(16'd3, 16'd40, 2'd2);
        send(16'd4, 16'd45, 2'd3);
        offer(16'd5, 16'd55);
        chk("t2_full_rdy", 32'(ev_rdy), 32'd0);
        step();
        chk("t2_busy", 32'(busy), 32'hF);
        chk("t2_gvt", 32'(gvt), 32'd25);
        chk("t2_err", 32'(err), 32'd0);

        // LP conflict: core3 free but LP2 in flight on core1
        done_pulse(2'd3);
        chk("t3_busy_after_done", 32'(busy), 32'h7);
        offer(16'd2, 16'd50);
        chk("t3_conflict_rdy", 32'(ev_rdy), 32'd0);
        @(negedge clk);
        done_vld     = 1'b1;
        done_core_id = 2'd1;
        #1;
        chk("t3_same_cycle_rdy", 32'(ev_rdy), 32'd0);
        @(negedge clk);
        done_vld = 1'b0;
        #1;
        expect_accept(2'd1);
        step();
        chk("t3_busy", 32'(busy), 32'h7);

        // stall skips core0; late stall does not cancel
        done_pulse(2'd0);
        done_pulse(2'd1);
        chk("t4_busy_pre", 32'(busy), 32'h4);
        stall = 4'b0001;
        send(16'd6, 16'd60, 2'd1);
        @(negedge clk);
        ev_vld = 1'b0;
        stall  = 4'b0010;
        #1;
        chk("t4_busy", 32'(busy), 32'h6);
        step();
        chk("t4_busy_hold", 32'(busy), 32'h6);
        chk("t4_gvt", 32'(gvt), 32'd40);
        stall = 4'b0000;

        // completion from an idle core
        done_pulse(2'd3);
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_busy", 32'(busy), 32'h6);
        step();
        step();
        chk("t5_err_sticky", 32'(err), 32'd1);

        // asynchronous reset mid-operation
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_err", 32'(err), 32'd0);
        chk("t6_rst_gvt", 32'(gvt), 32'hFFFF);
        @(negedge clk);
        reset_n = 1'b1;

        // same-cycle completion and dispatch
        send(16'd1, 16'd25, 2'd0);
        step();
        step();
        chk("t6_gvt_25", 32'(gvt), 32'd25);
        @(negedge clk);
        ev_msg       = {16'd7, 16'd70};
        ev_vld       = 1'b1;
        done_vld     = 1'b1;
        done_core_id = 2'd0;
        #1;
        expect_accept(2'd1);
        step();
        chk("t6_busy", 32'(busy), 32'h2);
        chk("t6_gvt_lag", 32'(gvt), 32'd25);
        step();
        chk("t6_gvt_70", 32'(gvt), 32'd70);
        chk("t6_err", 32'(err), 32'd0);

        repeat (3) step();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
